// File: rtl/ifm_out_fsm.sv
// ============================================================================
// Module      : ifm_out_fsm
// Description : Frame output sequencer. Reads per-frame status from the info
//               FIFO, forwards or drops the frame's beats from the data FIFO
//               onto AXI-Stream, and counts good and bad frames.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module ifm_out_fsm #(
    parameter int C_DROP_BAD  = 1,
    parameter int C_CNT_WIDTH = 32
) (
    input  logic                   rx_clk,
    input  logic                   rx_reset,
    input  logic [72:0]            data_fifo_rdata,
    input  logic                   data_fifo_empty,
    output logic                   data_fifo_rden,
    input  logic                   info_fifo_rdata,
    input  logic                   info_fifo_empty,
    output logic                   info_fifo_rden,
    output logic [63:0]            m_axis_tdata,
    output logic [7:0]             m_axis_tkeep,
    output logic                   m_axis_tlast,
    output logic                   m_axis_tuser,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic [C_CNT_WIDTH-1:0] good_frame_cnt,
    output logic [C_CNT_WIDTH-1:0] bad_frame_cnt
);

    localparam bit                   c_DROP    = (C_DROP_BAD != 0);
    localparam logic [C_CNT_WIDTH-1:0] c_CNT_ONE = C_CNT_WIDTH'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PASS = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic                   w_data_rden;
    logic                   w_info_rden;
    logic                   w_pass_pop;
    logic                   w_last_pop;
    logic                   r_status;
    logic [63:0]            r_tdata;
    logic [7:0]             r_tkeep;
    logic                   r_tlast;
    logic                   r_tuser;
    logic                   r_tvalid;
    logic [C_CNT_WIDTH-1:0] r_good_cnt;
    logic [C_CNT_WIDTH-1:0] r_bad_cnt;

    always_comb begin
        w_state_nxt = r_state;
        w_data_rden = 1'b0;
        w_info_rden = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!info_fifo_empty) begin
                    w_info_rden = 1'b1;
                    w_state_nxt = (info_fifo_rdata && c_DROP) ? S_DROP : S_PASS;
                end
            end
            S_PASS:  w_data_rden = !data_fifo_empty && (!r_tvalid || m_axis_tready);
            S_DROP:  w_data_rden = !data_fifo_empty;
            default: w_state_nxt = S_IDLE;
        endcase
        if (w_data_rden && data_fifo_rdata[72]) begin
            w_state_nxt = S_IDLE;
        end
        // FIFOs share this reset; popping them during reset would be meaningless
        if (rx_reset) begin
            w_data_rden = 1'b0;
            w_info_rden = 1'b0;
        end
    end

    assign w_pass_pop = (r_state == S_PASS) && w_data_rden;
    assign w_last_pop = w_data_rden && data_fifo_rdata[72];

    always_ff @(posedge rx_clk) begin
        if (rx_reset) begin
            r_state    <= S_IDLE;
            r_status   <= 1'b0;
            r_tdata    <= '0;
            r_tkeep    <= '0;
            r_tlast    <= 1'b0;
            r_tuser    <= 1'b0;
            r_tvalid   <= 1'b0;
            r_good_cnt <= '0;
            r_bad_cnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_info_rden) begin
                r_status <= info_fifo_rdata;
            end
            if (w_pass_pop) begin
                r_tdata  <= data_fifo_rdata[63:0];
                r_tkeep  <= data_fifo_rdata[71:64];
                r_tlast  <= data_fifo_rdata[72];
                r_tuser  <= r_status && data_fifo_rdata[72];
                r_tvalid <= 1'b1;
            end else if (r_tvalid && m_axis_tready) begin
                r_tvalid <= 1'b0;
            end
            if (w_pass_pop && data_fifo_rdata[72] && !r_status) begin
                r_good_cnt <= r_good_cnt + c_CNT_ONE;
            end
            // Dropped frames carry status 1 by construction
            if (w_last_pop && ((r_state == S_DROP) || r_status)) begin
                r_bad_cnt <= r_bad_cnt + c_CNT_ONE;
            end
        end
    end

    assign data_fifo_rden = w_data_rden;
    assign info_fifo_rden = w_info_rden;
    assign m_axis_tdata   = r_tdata;
    assign m_axis_tkeep   = r_tkeep;
    assign m_axis_tlast   = r_tlast;
    assign m_axis_tuser   = r_tuser;
    assign m_axis_tvalid  = r_tvalid;
    assign good_frame_cnt = r_good_cnt;
    assign bad_frame_cnt  = r_bad_cnt;

endmodule

`default_nettype wire
